mem_responder: RTL and testbench

//  Memory-side responder for the memEN/RW/MFC handshake driven by the load/store control FSM.

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder_mem_array.sv | 31 +++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memEN/RW/MFC memory handshake.
// The load/store control FSM imports the same definitions.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_responder_if.sv
// Memory request/response bus between the load/store controller (master)
// and the memory responder (slave).
interface mem_responder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              memEN;
    logic              RW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              MFC;
    logic              addr_err;

    modport master (
        output memEN, RW, addr, wdata,
        input  rdata, MFC, addr_err
    );

    modport slave (
        input  memEN, RW, addr, wdata,
        output rdata, MFC, addr_err
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, registered read.
// Out-of-range addresses never write and read back as zero.
module mem_array #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    assign in_range = ({1'b0, addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= din;
        end
        if (in_range) begin
            dout <= mem[addr];
        end else begin
            dout <= '0;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a memEN request, waits LATENCY cycles,
// performs the word access and holds MFC until memEN is released.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam logic [3:0]      LAT_L   = 4'(LATENCY);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              req_rw, req_rw_n;
    logic [ADDR_W-1:0] req_addr, req_addr_n;
    logic [DATA_W-1:0] req_wdata, req_wdata_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              mfc_q, mfc_n;
    logic              err_q, err_n;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              req_in_range;

    // The RAM reads continuously: the live address while idle, the latched one
    // afterwards, so mem_dout already holds the word on the completion edge.
    assign mem_addr     = (state == IDLE) ? bus.addr : req_addr;
    assign req_in_range = ({1'b0, req_addr} < DEPTH_L);

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .din  (req_wdata),
        .dout (mem_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_rw    <= RW_READ;
            req_addr  <= '0;
            req_wdata <= '0;
            rdata_q   <= '0;
            mfc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            req_rw    <= req_rw_n;
            req_addr  <= req_addr_n;
            req_wdata <= req_wdata_n;
            rdata_q   <= rdata_n;
            mfc_q     <= mfc_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_rw_n    = req_rw;
        req_addr_n  = req_addr;
        req_wdata_n = req_wdata;
        rdata_n     = rdata_q;
        mfc_n       = mfc_q;
        err_n       = err_q;
        mem_we      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.memEN) begin
                    req_rw_n    = bus.RW;
                    req_addr_n  = bus.addr;
                    req_wdata_n = bus.wdata;
                    cnt_n       = LAT_L;
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                if (!bus.memEN) begin
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    state_n = DONE;
                    mfc_n   = 1'b1;
                    if (!req_in_range) begin
                        err_n = 1'b1;
                        if (req_rw == RW_READ) begin
                            rdata_n = '0;
                        end
                    end else if (req_rw == RW_READ) begin
                        rdata_n = mem_dout;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!bus.memEN) begin
                    mfc_n   = 1'b0;
                    err_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rdata    = rdata_q;
    assign bus.MFC      = mfc_q;
    assign bus.addr_err = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: dut0 (LATENCY=2, DEPTH=48) and dut1 (LATENCY=0, DEPTH=64).
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(6), .DATA_W(16)) b0 ();
    mem_responder_if #(.ADDR_W(6), .DATA_W(16)) b1 ();

    mem_responder #(.ADDR_W(6), .DATA_W(16), .DEPTH(48), .LATENCY(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    mem_responder #(.ADDR_W(6), .DATA_W(16), .DEPTH(64), .LATENCY(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic en, input logic rw,
                         input logic [5:0] a, input logic [15:0] d);
        if (w == 0) begin
            b0.memEN = en; b0.RW = rw; b0.addr = a; b0.wdata = d;
        end else begin
            b1.memEN = en; b1.RW = rw; b1.addr = a; b1.wdata = d;
        end
    endtask

    task automatic get(input int w, output logic mfc, output logic err, output logic [15:0] rd);
        if (w == 0) begin
            mfc = b0.MFC; err = b0.addr_err; rd = b0.rdata;
        end else begin
            mfc = b1.MFC; err = b1.addr_err; rd = b1.rdata;
        end
    endtask

    // Full request: edges counts rising edges after the accept edge until MFC (99 = timeout).
    task automatic xfer(input int w, input logic rw, input logic [5:0] a, input logic [15:0] d,
                        output int edges, output logic [15:0] rd, output logic err);
        logic mfc;
        drive(w, 1'b1, rw, a, d);
        step();
        edges = 99;
        for (int n = 1; n <= 20; n++) begin
            step();
            get(w, mfc, err, rd);
            if (mfc) begin
                edges = n;
                break;
            end
        end
        get(w, mfc, err, rd);
        drive(w, 1'b0, rw, a, d);
        step();
    endtask

    task automatic test_reset();
        logic mfc, err;
        logic [15:0] rd;
        rst = 1'b1;
        drive(0, 1'b0, 1'b1, 6'd0, 16'h0);
        drive(1, 1'b0, 1'b1, 6'd0, 16'h0);
        step(); step();
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            get(w, mfc, err, rd);
            checks++;
            if ({mfc, err, rd} !== 18'h0) begin
                failures++;
                $display("FAIL reset dut%0d: mfc=%b err=%b rdata=%h expected 0 0 0000", w, mfc, err, rd);
            end
        end
    endtask

    task automatic test_write_read();
        logic mfc, err;
        logic [15:0] rd;
        int edges;
        drive(0, 1'b1, 1'b0, 6'd5, 16'hBEEF);
        step();
        for (int n = 1; n <= 2; n++) begin
            step();
            get(0, mfc, err, rd);
            checks++;
            if (mfc !== 1'b0) begin
                failures++;
                $display("FAIL wr_latency edge%0d: mfc=%b expected 0", n, mfc);
            end
        end
        step();
        get(0, mfc, err, rd);
        checks++;
        if ({mfc, err} !== 2'b10) begin
            failures++;
            $display("FAIL wr_complete: mfc=%b err=%b expected 1 0", mfc, err);
        end
        drive(0, 1'b0, 1'b0, 6'd5, 16'hBEEF);
        step();
        get(0, mfc, err, rd);
        checks++;
        if (mfc !== 1'b0) begin
            failures++;
            $display("FAIL wr_release: mfc=%b expected 0", mfc);
        end
        xfer(0, 1'b1, 6'd5, 16'h0, edges, rd, err);
        checks++;
        if (edges != 3 || rd !== 16'hBEEF || err !== 1'b0) begin
            failures++;
            $display("FAIL rd_after_wr: edges=%0d rdata=%h err=%b expected 3 beef 0", edges, rd, err);
        end
    endtask

    task automatic test_abort();
        logic mfc, err;
        logic [15:0] rd;
        int edges, highs;
        xfer(0, 1'b0, 6'd9, 16'h1111, edges, rd, err);
        drive(0, 1'b1, 1'b0, 6'd9, 16'h2222);
        step();
        step();
        drive(0, 1'b0, 1'b0, 6'd9, 16'h2222);
        highs = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            get(0, mfc, err, rd);
            if (mfc) highs++;
        end
        checks++;
        if (highs != 0) begin
            failures++;
            $display("FAIL abort_mfc: mfc high for %0d cycles expected 0", highs);
        end
        xfer(0, 1'b1, 6'd9, 16'h0, edges, rd, err);
        checks++;
        if (edges != 3 || rd !== 16'h1111) begin
            failures++;
            $display("FAIL abort_no_write: edges=%0d rdata=%h expected 3 1111", edges, rd);
        end
    endtask

    task automatic test_out_of_range();
        logic mfc, err;
        logic [15:0] rd;
        int edges;
        xfer(0, 1'b0, 6'd2, 16'h1234, edges, rd, err);
        xfer(0, 1'b0, 6'd50, 16'hDEAD, edges, rd, err);
        checks++;
        if (edges != 3 || err !== 1'b1) begin
            failures++;
            $display("FAIL oor_write: edges=%0d err=%b expected 3 1", edges, err);
        end
        get(0, mfc, err, rd);
        checks++;
        if ({mfc, err} !== 2'b00) begin
            failures++;
            $display("FAIL oor_release: mfc=%b err=%b expected 0 0", mfc, err);
        end
        xfer(0, 1'b1, 6'd50, 16'h0, edges, rd, err);
        checks++;
        if (edges != 3 || err !== 1'b1 || rd !== 16'h0000) begin
            failures++;
            $display("FAIL oor_read: edges=%0d err=%b rdata=%h expected 3 1 0000", edges, err, rd);
        end
        xfer(0, 1'b1, 6'd2, 16'h0, edges, rd, err);
        checks++;
        if (err !== 1'b0 || rd !== 16'h1234) begin
            failures++;
            $display("FAIL oor_no_corrupt: err=%b rdata=%h expected 0 1234", err, rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic mfc, err;
        logic [15:0] rd;
        int edges;
        xfer(0, 1'b0, 6'd7, 16'h7777, edges, rd, err);
        xfer(0, 1'b1, 6'd7, 16'h0, edges, rd, err);
        drive(0, 1'b1, 1'b0, 6'd7, 16'hAAAA);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 6'd7, 16'hAAAA);
        get(0, mfc, err, rd);
        checks++;
        if ({mfc, err, rd} !== 18'h0) begin
            failures++;
            $display("FAIL rst_mid_wait: mfc=%b err=%b rdata=%h expected 0 0 0000", mfc, err, rd);
        end
        step();
        xfer(0, 1'b1, 6'd7, 16'h0, edges, rd, err);
        checks++;
        if (edges != 3 || rd !== 16'h7777) begin
            failures++;
            $display("FAIL rst_ram_kept: edges=%0d rdata=%h expected 3 7777", edges, rd);
        end
    endtask

    task automatic test_zero_latency_hold();
        logic mfc, err;
        logic [15:0] rd;
        int edges, bad;
        xfer(1, 1'b0, 6'd20, 16'h5A5A, edges, rd, err);
        checks++;
        if (edges != 1) begin
            failures++;
            $display("FAIL lat0_write: edges=%0d expected 1", edges);
        end
        drive(1, 1'b1, 1'b1, 6'd20, 16'h0);
        step();
        step();
        get(1, mfc, err, rd);
        checks++;
        if (mfc !== 1'b1 || rd !== 16'h5A5A) begin
            failures++;
            $display("FAIL lat0_read: mfc=%b rdata=%h expected 1 5a5a", mfc, rd);
        end
        // change the live inputs while held in DONE: nothing must move
        drive(1, 1'b1, 1'b0, 6'd20, 16'h0F0F);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            get(1, mfc, err, rd);
            if (mfc !== 1'b1 || rd !== 16'h5A5A) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lat0_hold: %0d bad cycles expected 0", bad);
        end
        drive(1, 1'b0, 1'b1, 6'd20, 16'h0);
        step();
        xfer(1, 1'b1, 6'd20, 16'h0, edges, rd, err);
        checks++;
        if (edges != 1 || rd !== 16'h5A5A) begin
            failures++;
            $display("FAIL lat0_single: edges=%0d rdata=%h expected 1 5a5a", edges, rd);
        end
    endtask

    task automatic test_latched_inputs();
        logic mfc, err;
        logic [15:0] rd;
        int edges;
        xfer(0, 1'b0, 6'd12, 16'hC0C0, edges, rd, err);
        drive(0, 1'b1, 1'b0, 6'd11, 16'h0B0B);
        step();
        drive(0, 1'b1, 1'b1, 6'd12, 16'hFFFF);
        edges = 99;
        for (int n = 1; n <= 20; n++) begin
            step();
            get(0, mfc, err, rd);
            if (mfc) begin
                edges = n;
                break;
            end
        end
        checks++;
        if (edges != 3) begin
            failures++;
            $display("FAIL latch_latency: edges=%0d expected 3", edges);
        end
        drive(0, 1'b0, 1'b1, 6'd12, 16'hFFFF);
        step();
        xfer(0, 1'b1, 6'd11, 16'h0, edges, rd, err);
        checks++;
        if (rd !== 16'h0B0B) begin
            failures++;
            $display("FAIL latch_addr11: rdata=%h expected 0b0b", rd);
        end
        xfer(0, 1'b1, 6'd12, 16'h0, edges, rd, err);
        checks++;
        if (rd !== 16'hC0C0) begin
            failures++;
            $display("FAIL latch_addr12: rdata=%h expected c0c0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_out_of_range();
        test_reset_mid_wait();
        test_zero_latency_hold();
        test_latched_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
